imem_boot_loader: RTL

Boot-time controller that fills the byte-addressable instruction memory from a byte stream (UART/debug bridge) before the core runs. It receives a little-endian length header, then writes each payload byte to consecutive IMEM byte addresses. The core is held in reset until the load completes. It sits between the host byte link and the IMEM write port, and drives the core's reset.

---
 rtl/imem_boot_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: fills IMEM from a length-prefixed byte stream, holding the core in reset until done.
// Optional trailing checksum byte enabled by defining IMEM_BOOT_CSUM_EN.
module imem_boot_loader #(
    parameter int                IMEM_SIZE = 1024,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              core_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] byte_cnt_o
);
`ifdef IMEM_BOOT_CSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_CSUM, S_DONE, S_ERR} state_t;
    localparam state_t LAST_NEXT = S_CSUM;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_DONE, S_ERR} state_t;
    localparam state_t LAST_NEXT = S_DONE;
`endif
    state_t              state_q, state_d;
    logic [23:0]         hdr_q, hdr_d;
    logic [1:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]   len_q, len_d, cnt_q, cnt_d, addr_q, addr_d, cnt_inc;
    logic [7:0]          wdata_q, wdata_d;
    logic                we_q, we_d, crst_q, hs;
    logic [31:0]         l_full;
`ifdef IMEM_BOOT_CSUM_EN
    logic [7:0]          csum_q, csum_d;
    assign rx_ready_o = state_q inside {S_HDR, S_LOAD, S_CSUM};
`else
    assign rx_ready_o = state_q inside {S_HDR, S_LOAD};
`endif
    assign busy_o       = rx_ready_o;
    assign done_o       = state_q == S_DONE;
    assign err_o        = state_q == S_ERR;
    assign core_rst_n_o = crst_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign byte_cnt_o   = cnt_q;
    assign hs           = rx_valid_i && rx_ready_o;
    // Header arrives LSB first: the three earlier bytes sit in hdr_q, the 4th is live.
    assign l_full       = {rx_data_i, hdr_q};
    assign cnt_inc      = cnt_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_BOOT_CSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_ERR: if (start_i) begin
                state_d = S_HDR;
                cnt_d   = '0;
                idx_d   = '0;
`ifdef IMEM_BOOT_CSUM_EN
                csum_d  = '0;
`endif
            end
            S_HDR: if (hs) begin
                idx_d = idx_q + 2'd1;
                hdr_d = {rx_data_i, hdr_q[23:8]};
                if (idx_q == 2'd3) begin
                    len_d   = ADDR_W'(l_full);
                    state_d = (l_full == 32'd0) ? LAST_NEXT :
                              (l_full > 32'(IMEM_SIZE)) ? S_ERR : S_LOAD;
                end
            end
            S_LOAD: if (hs) begin
                we_d    = 1'b1;
                addr_d  = BASE_ADDR + cnt_q;
                wdata_d = rx_data_i;
                cnt_d   = cnt_inc;
`ifdef IMEM_BOOT_CSUM_EN
                csum_d  = csum_q + rx_data_i;
`endif
                if (cnt_inc == len_q) state_d = LAST_NEXT;
            end
`ifdef IMEM_BOOT_CSUM_EN
            S_CSUM: if (hs) state_d = (rx_data_i == csum_q) ? S_DONE : S_ERR;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hdr_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            crst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            crst_q  <= state_q == S_DONE;
        end
    end

`ifdef IMEM_BOOT_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end
`endif
endmodule
